// File: rtl/uds_row_if.sv
// Engine-to-serializer word capture and row stream toward write-back.
interface uds_row_if #(
    parameter int unsigned WORD_W = 1792,
    parameter int unsigned ROW_W  = 128,
    parameter int unsigned IDX_W  = 4
);
    logic [WORD_W-1:0] odata;
    logic              odata_valid;
    logic [1:0]        function_mode;
    logic [ROW_W-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;
    logic [IDX_W-1:0]  row_idx;
    logic              row_last;

    modport master (
        output odata, odata_valid, function_mode, row_ready,
        input  row_data, row_valid, row_idx, row_last
    );

    modport slave (
        input  odata, odata_valid, function_mode, row_ready,
        output row_data, row_valid, row_idx, row_last
    );
endinterface

// File: rtl/uds_row_serializer.sv
// Two-entry capture buffer for engine result words, drained as 128-bit rows
// whose count per word depends on the mode captured with that word.
module uds_row_serializer #(
    parameter int unsigned A         = 64,
    parameter int unsigned A_BITS    = 16,
    parameter int unsigned UP_ROWS   = 14,
    parameter int unsigned DOWN_ROWS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    uds_row_if.slave bus,
    input  logic     ovf_clr,
    output logic     overflow,
    output logic     busy
);
    localparam int unsigned WORD_W = 2 * (A - 8) * A_BITS;
    localparam int unsigned ROW_W  = 8 * A_BITS;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SH_W   = $clog2(WORD_W) + 1;

    logic [WORD_W-1:0] mem_q [2];
    logic [1:0]        mode_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [IDX_W-1:0]  r_q;

    logic              valid_c;
    logic [IDX_W-1:0]  rows_c;
    logic              last_c;
    logic              beat_c;
    logic              pop_c;
    logic              slot_c;
    logic              capture_c;
    logic              drop_c;
    logic [WORD_W-1:0] head_c;
    logic [SH_W-1:0]   shamt_c;
    logic              unused_mode_lsb;

    assign unused_mode_lsb = bus.function_mode[0];

    // A full buffer still accepts a word when the head is retiring this cycle.
    always_comb begin
        valid_c   = (count_q != 2'd0);
        rows_c    = mode_q[rd_ptr_q] ? IDX_W'(UP_ROWS) : IDX_W'(DOWN_ROWS);
        last_c    = (r_q == rows_c - IDX_W'(1));
        beat_c    = valid_c & bus.row_ready;
        pop_c     = beat_c & last_c;
        slot_c    = (count_q != 2'd2) | pop_c;
        capture_c = bus.odata_valid & slot_c;
        drop_c    = bus.odata_valid & ~slot_c;
        head_c    = mem_q[rd_ptr_q];
        shamt_c   = SH_W'(r_q) * SH_W'(ROW_W);
    end

    assign bus.row_data  = ROW_W'(head_c >> shamt_c);
    assign bus.row_valid = valid_c;
    assign bus.row_idx   = r_q;
    assign bus.row_last  = valid_c & last_c;
    assign busy          = valid_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            mode_q   <= '0;
        end else if (capture_c) begin
            mem_q[wr_ptr_q]  <= bus.odata;
            mode_q[wr_ptr_q] <= bus.function_mode[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            r_q      <= '0;
            overflow <= 1'b0;
        end else begin
            if (capture_c) wr_ptr_q <= ~wr_ptr_q;
            if (pop_c)     rd_ptr_q <= ~rd_ptr_q;

            unique case ({capture_c, pop_c})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase

            if (beat_c) r_q <= last_c ? '0 : r_q + IDX_W'(1);

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_c)       overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uds_row_serializer.sv
// Directed vector bench for uds_row_serializer; row k of word tag t carries item {t, k}.
module tb_uds_row_serializer;
    localparam int unsigned WORD_W = 1792;
    localparam int unsigned ROW_W  = 128;

    typedef struct {
        logic       cap;
        logic       up;
        logic [7:0] tag;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [3:0] idx;
        logic       last;
        logic [7:0] etag;
        logic       ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    logic ovf_clr;
    logic overflow;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    uds_row_if #(.WORD_W(WORD_W), .ROW_W(ROW_W), .IDX_W(4)) bus ();

    uds_row_serializer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ovf_clr  (ovf_clr),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] make_word(input int tag);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < 14; k++)
            for (int j = 0; j < 8; j++)
                w[(k*8+j)*16 +: 16] = {8'(tag), 8'(k)};
        return w;
    endfunction

    function automatic vec_t mk(input bit cap, input bit up, input int tag, input bit rdy,
                                input bit clr, input bit ev, input int idx, input bit last,
                                input int etag, input bit ovf);
        vec_t v;
        v.cap = cap; v.up = up; v.tag = 8'(tag); v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.idx = 4'(idx); v.last = last; v.etag = 8'(etag); v.ovf = ovf;
        return v;
    endfunction

    function automatic void add(input bit cap, input bit up, input int tag, input bit rdy,
                                input bit clr, input bit ev, input int idx, input bit last,
                                input int etag, input bit ovf);
        vecs.push_back(mk(cap, up, tag, rdy, clr, ev, idx, last, etag, ovf));
    endfunction

    function automatic void drain(input int tag, input int first, input int nrows, input bit ovf);
        for (int k = first; k < nrows; k++)
            add(0, 0, 0, 1, 0, 1, k, (k == nrows - 1), tag, ovf);
    endfunction

    task automatic chk(input string nm, input int vi, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, vi, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check registered-state outputs.
    task automatic run_vec(input vec_t v, input int vi);
        logic [15:0] item;
        @(negedge clk);
        bus.odata         = make_word(int'(v.tag));
        bus.odata_valid   = v.cap;
        bus.function_mode = {v.up, 1'b0};
        bus.row_ready     = v.rdy;
        ovf_clr           = v.clr;
        #1;
        chk("row_valid", vi, ROW_W'(bus.row_valid), ROW_W'(v.ev));
        chk("row_idx",   vi, ROW_W'(bus.row_idx),   ROW_W'(v.idx));
        chk("row_last",  vi, ROW_W'(bus.row_last),  ROW_W'(v.last));
        chk("busy",      vi, ROW_W'(busy),          ROW_W'(v.ev));
        chk("overflow",  vi, ROW_W'(overflow),      ROW_W'(v.ovf));
        if (v.ev) begin
            item = {v.etag, 4'h0, v.idx};
            chk("row_data", vi, bus.row_data, {8{item}});
        end
    endtask

    task automatic chk_all_zero(input int vi);
        chk("rst_valid", vi, ROW_W'(bus.row_valid), '0);
        chk("rst_idx",   vi, ROW_W'(bus.row_idx),   '0);
        chk("rst_last",  vi, ROW_W'(bus.row_last),  '0);
        chk("rst_busy",  vi, ROW_W'(busy),          '0);
        chk("rst_ovf",   vi, ROW_W'(overflow),      '0);
        chk("rst_data",  vi, bus.row_data,          '0);
    endtask

    initial begin
        rst_n             = 1'b0;
        ovf_clr           = 1'b0;
        bus.odata         = '0;
        bus.odata_valid   = 1'b0;
        bus.function_mode = 2'b00;
        bus.row_ready     = 1'b0;

        // Upsample word: 14 rows, last on 13, idle afterwards.
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        drain(1, 0, 14, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Downsample word with stalls: data must hold while row_ready is low.
        add(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1, 2, 0, 2, 0);
        add(0, 0, 0, 1, 0, 1, 2, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1, 3, 1, 2, 0);
        add(0, 0, 0, 1, 0, 1, 3, 1, 2, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Alternating up then down back-to-back with no bubble.
        add(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 4, 1, 0, 1, 0, 0, 3, 0);
        drain(3, 1, 14, 0);
        drain(4, 0, 4, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Full buffer plus pop on the last row accepts the arriving word.
        add(1, 0, 11, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 12, 1, 0, 1, 0, 0, 11, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0, 11, 0);
        add(0, 0, 0, 1, 0, 1, 2, 0, 11, 0);
        add(1, 0, 13, 1, 0, 1, 3, 1, 11, 0);
        drain(12, 0, 4, 0);
        drain(13, 0, 4, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Three words with no readiness: third dropped, overflow sticky.
        add(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 6, 0, 0, 1, 0, 0, 5, 0);
        add(1, 1, 7, 0, 0, 1, 0, 0, 5, 0);
        drain(5, 0, 4, 1);
        drain(6, 0, 4, 1);
        // Clear, then drop coinciding with clear keeps the flag, then clear alone.
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 8, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 9, 0, 0, 1, 0, 0, 8, 0);
        add(1, 1, 10, 0, 1, 1, 0, 0, 8, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 8, 1);
        add(0, 0, 0, 1, 1, 1, 1, 0, 8, 1);
        add(0, 0, 0, 1, 0, 1, 2, 0, 8, 0);
        add(0, 0, 0, 1, 0, 1, 3, 1, 8, 0);
        drain(9, 0, 4, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero(-1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset asserted while row 5 of an upsample word is presented.
        run_vec(mk(1, 1, 20, 1, 0, 0, 0, 0, 0, 0), 1000);
        for (int k = 0; k < 5; k++)
            run_vec(mk(0, 0, 0, 1, 0, 1, k, 0, 20, 0), 1001 + k);
        run_vec(mk(0, 0, 0, 0, 0, 1, 5, 0, 20, 0), 1006);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero(1007);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(1, 0, 21, 1, 0, 0, 0, 0, 0, 0), 1010);
        for (int k = 0; k < 4; k++)
            run_vec(mk(0, 0, 0, 1, 0, 1, k, (k == 3), 21, 0), 1011 + k);
        run_vec(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1015);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
